// File: rtl/rpc2_ctrl_axi3_wr_sequencer.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_axi3_wr_sequencer
//
// Write-burst sequencer for the AXI3 write path of the RPC2 controller.
// Accepted write-address commands are queued and handed one at a time to the
// write-data control block. While a burst is active, AXI_WREADY follows the
// write-data FIFO back-pressure and beats are counted against the burst
// length. After the WLAST beat, one B-response entry is produced per burst.
// A burst with the wrong number of beats is reported as SLVERR.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   cmd_*             : write command in (id, low address bits, len, size,
//                       burst); cmd_ready is high when the queue is not full
//   AXI_W*            : AXI write-data channel handshake (VALID, LAST, ID in;
//                       READY out)
//   wdat_full         : write-data FIFO full; gates AXI_WREADY
//   wready_req        : one-cycle burst-start pulse to data control
//   wready_size/fixed/strb/id : parameters of the active burst; they hold
//                       from one burst start until the next
//   wready_done       : WLAST beat accepted by data control
//   bresp_*           : B-response entry with valid/ready handshake
//   busy              : FSM active or commands still queued
// ---------------------------------------------------------------------------
module rpc2_ctrl_axi3_wr_sequencer #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int CMD_DEPTH        = 4,
    localparam int STRB_W          = C_AXI_DATA_WIDTH / 8,
    localparam int LANE_BITS       = (C_AXI_DATA_WIDTH == 64) ? 3 : 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [C_AXI_ID_WIDTH-1:0] cmd_id,
    input  logic [LANE_BITS-1:0]      cmd_addr,
    input  logic [3:0]                cmd_len,
    input  logic [1:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    input  logic                      AXI_WVALID,
    input  logic                      AXI_WLAST,
    input  logic [C_AXI_ID_WIDTH-1:0] AXI_WID,
    output logic                      AXI_WREADY,
    input  logic                      wdat_full,
    output logic                      wready_req,
    output logic [1:0]                wready_size,
    output logic                      wready_fixed,
    output logic [STRB_W-1:0]         wready_strb,
    output logic [C_AXI_ID_WIDTH-1:0] wready_id,
    input  logic                      wready_done,
    output logic                      bresp_valid,
    output logic [C_AXI_ID_WIDTH-1:0] bresp_id,
    output logic [1:0]                bresp_resp,
    input  logic                      bresp_ready,
    output logic                      busy
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CMD_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LANE_MAX  = 3'(LANE_BITS);
    localparam logic [4:0]       BEAT_SAT  = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Queue entries hold the already-derived burst parameters, so the start
    // of a burst is a plain registered read of the queue head.
    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0] id;
        logic [3:0]                len;
        logic [1:0]                size;
        logic                      fixed;
        logic [STRB_W-1:0]         strb;
    } cmd_entry_t;

    cmd_entry_t           mem [CMD_DEPTH];
    cmd_entry_t           push_entry;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 push;
    logic                 pop;
    logic                 full;

    state_t               state_reg;
    logic [3:0]           len_reg;
    logic [4:0]           beat_cnt_reg;
    logic                 err_reg;

    logic                 beat;
    logic                 done;
    logic                 err_next;
    logic [2:0]           eff_size;
    logic [STRB_W-1:0]    push_strb;

    // -----------------------------------------------------------------------
    // First-beat lane mask. The transfer size is clamped to the bus width;
    // a lane belongs to the first beat when it lies in the same size-aligned
    // block as the start address.
    // -----------------------------------------------------------------------
    assign eff_size = ({1'b0, cmd_size} > LANE_MAX) ? LANE_MAX : {1'b0, cmd_size};

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            localparam logic [LANE_BITS-1:0] LANE = LANE_BITS'(gi);
            assign push_strb[gi] = ((LANE >> eff_size) == (cmd_addr >> eff_size));
        end
    endgenerate

    always_comb begin
        push_entry       = '0;
        push_entry.id    = cmd_id;
        push_entry.len   = cmd_len;
        push_entry.size  = cmd_size;
        push_entry.fixed = (cmd_burst == 2'b00);  // WRAP and reserved run as INCR
        push_entry.strb  = push_strb;
    end

    // -----------------------------------------------------------------------
    // Command queue. Fullness comes from the registered count, so cmd_ready
    // stays low while full even when the head is popped in the same cycle.
    // -----------------------------------------------------------------------
    assign full      = (count_reg == CNT_FULL);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign pop       = (state_reg == ST_LOAD);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data-phase qualification. Beats carrying a foreign WID are ignored.
    // -----------------------------------------------------------------------
    assign AXI_WREADY = (state_reg == ST_DATA) & ~wdat_full;
    assign beat       = AXI_WREADY & AXI_WVALID & (AXI_WID == wready_id);
    assign done       = (state_reg == ST_DATA) & wready_done;

    // beat_cnt is the count before the current beat: a beat at index > len
    // means WLAST was missing, and WLAST at any index other than len is early.
    assign err_next = err_reg
                    | (beat & (beat_cnt_reg > {1'b0, len_reg}))
                    | (done & (beat_cnt_reg != {1'b0, len_reg}));

    assign busy = (state_reg != ST_IDLE) | (count_reg != '0);

    // -----------------------------------------------------------------------
    // Burst FSM. The burst parameters are loaded on entry to LOAD so that
    // they are visible together with the wready_req pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wready_req   <= 1'b0;
            wready_size  <= '0;
            wready_fixed <= 1'b0;
            wready_strb  <= '0;
            wready_id    <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
            bresp_valid  <= 1'b0;
            bresp_id     <= '0;
            bresp_resp   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (count_reg != '0) begin
                        state_reg    <= ST_LOAD;
                        wready_req   <= 1'b1;
                        wready_size  <= mem[rd_ptr_reg].size;
                        wready_fixed <= mem[rd_ptr_reg].fixed;
                        wready_strb  <= mem[rd_ptr_reg].strb;
                        wready_id    <= mem[rd_ptr_reg].id;
                        len_reg      <= mem[rd_ptr_reg].len;
                    end
                end
                ST_LOAD: begin
                    state_reg    <= ST_DATA;
                    wready_req   <= 1'b0;
                    beat_cnt_reg <= '0;
                    err_reg      <= 1'b0;
                end
                ST_DATA: begin
                    err_reg <= err_next;
                    if (beat && (beat_cnt_reg != BEAT_SAT)) begin
                        beat_cnt_reg <= beat_cnt_reg + 5'd1;
                    end
                    if (done) begin
                        state_reg   <= ST_RESP;
                        bresp_valid <= 1'b1;
                        bresp_id    <= wready_id;
                        bresp_resp  <= err_next ? 2'b10 : 2'b00;
                    end
                end
                ST_RESP: begin
                    if (bresp_ready) begin
                        state_reg   <= ST_IDLE;
                        bresp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpc2_ctrl_axi3_wr_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for rpc2_ctrl_axi3_wr_sequencer (32-bit data, 4-bit ID, depth 4).
// Directed commands push their hand-computed burst-start and B-response
// expectations into queues; a monitor on the falling edge pops and compares
// whenever wready_req pulses or a B response handshakes. Timing-specific
// properties are checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_rpc2_ctrl_axi3_wr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_id;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [1:0] cmd_size;
    logic [1:0] cmd_burst;
    logic       AXI_WVALID;
    logic       AXI_WLAST;
    logic [3:0] AXI_WID;
    logic       AXI_WREADY;
    logic       wdat_full;
    logic       wready_req;
    logic [1:0] wready_size;
    logic       wready_fixed;
    logic [3:0] wready_strb;
    logic [3:0] wready_id;
    logic       wready_done;
    logic       bresp_valid;
    logic [3:0] bresp_id;
    logic [1:0] bresp_resp;
    logic       bresp_ready;
    logic       busy;

    always #5 clk = ~clk;

    // Data control reports the accepted WLAST beat of the active burst.
    assign wready_done = AXI_WVALID & AXI_WREADY & AXI_WLAST & (AXI_WID == wready_id);

    rpc2_ctrl_axi3_wr_sequencer #(
        .C_AXI_ID_WIDTH  (4),
        .C_AXI_DATA_WIDTH(32),
        .CMD_DEPTH       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_id      (cmd_id),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_size    (cmd_size),
        .cmd_burst   (cmd_burst),
        .AXI_WVALID  (AXI_WVALID),
        .AXI_WLAST   (AXI_WLAST),
        .AXI_WID     (AXI_WID),
        .AXI_WREADY  (AXI_WREADY),
        .wdat_full   (wdat_full),
        .wready_req  (wready_req),
        .wready_size (wready_size),
        .wready_fixed(wready_fixed),
        .wready_strb (wready_strb),
        .wready_id   (wready_id),
        .wready_done (wready_done),
        .bresp_valid (bresp_valid),
        .bresp_id    (bresp_id),
        .bresp_resp  (bresp_resp),
        .bresp_ready (bresp_ready),
        .busy        (busy)
    );

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] size;
        logic       fixed;
        logic [3:0] strb;
    } load_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    load_t exp_load[$];
    b_t    exp_b[$];
    load_t le;
    b_t    be;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (wready_req) begin
                if (exp_load.size() == 0) begin
                    chk("load_unexpected", wready_req, 0);
                end else begin
                    le = exp_load.pop_front();
                    chk("load_id", wready_id, le.id);
                    chk("load_size", wready_size, le.size);
                    chk("load_fixed", wready_fixed, le.fixed);
                    chk("load_strb", wready_strb, le.strb);
                    $display("LOAD  id=%0d size=%0d fixed=%0d strb=%b",
                             wready_id, wready_size, wready_fixed, wready_strb);
                end
            end
            if (bresp_valid && bresp_ready) begin
                if (exp_b.size() == 0) begin
                    chk("bresp_unexpected", bresp_valid, 0);
                end else begin
                    be = exp_b.pop_front();
                    chk("bresp_id", bresp_id, be.id);
                    chk("bresp_resp", bresp_resp, be.resp);
                    $display("BRESP id=%0d resp=%b", bresp_id, bresp_resp);
                end
            end
        end
    end

    task automatic push_cmd(input logic [3:0] id, input logic [1:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input logic [1:0] burst,
                            input logic [3:0] e_strb, input logic e_fixed, input logic [1:0] e_resp,
                            input bit track_load, input bit track_b);
        load_t l;
        b_t    b;
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        l.id = id; l.size = size; l.fixed = e_fixed; l.strb = e_strb;
        b.id = id; b.resp = e_resp;
        if (track_load) exp_load.push_back(l);
        if (track_b) exp_b.push_back(b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [3:0] id, input bit last);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        AXI_WVALID = 1'b1;
        AXI_WID    = id;
        AXI_WLAST  = last;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = AXI_WREADY;
            @(posedge clk); #1;
            n++;
        end
        chk("beat_accept", acc, 1);
        AXI_WVALID = 1'b0;
        AXI_WLAST  = 1'b0;
    endtask

    task automatic beats(input logic [3:0] id, input int cnt);
        for (int i = 0; i < cnt; i++) beat(id, i == cnt - 1);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wready_req && n < 60);
        chk("load_seen", wready_req, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_burst = '0; AXI_WVALID = 1'b0; AXI_WLAST = 1'b0; AXI_WID = '0;
        wdat_full = 1'b0; bresp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wready", AXI_WREADY, 0);
        chk("rst_req", wready_req, 0);
        chk("rst_strb", wready_strb, 0);
        chk("rst_fixed", wready_fixed, 0);
        chk("rst_bvalid", bresp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single INCR, addr 1, size 0, len 3, id 5: latency and OKAY
        push_cmd(4'd5, 2'd1, 4'd3, 2'd0, 2'b01, 4'b0010, 1'b0, 2'b00, 1, 1);
        @(negedge clk);
        chk("lat_c1_req", wready_req, 0);
        chk("lat_c1_busy", busy, 1);
        @(negedge clk);
        chk("lat_c2_req", wready_req, 1);
        chk("lat_c2_wready", AXI_WREADY, 0);
        @(posedge clk); #1;
        beats(4'd5, 4);
        @(negedge clk);
        chk("bvalid_lat", bresp_valid, 1);
        chk("wready_drop", AXI_WREADY, 0);
        @(posedge clk); #1;
        wait_idle();

        // Back-pressure for 3 cycles in mid-burst
        push_cmd(4'd5, 2'd2, 4'd3, 2'd1, 2'b01, 4'b1100, 1'b0, 2'b00, 1, 1);
        wait_load();
        beat(4'd5, 0);
        beat(4'd5, 0);
        wdat_full = 1'b1; AXI_WVALID = 1'b1; AXI_WID = 4'd5;
        repeat (3) begin
            @(negedge clk);
            chk("bp_wready", AXI_WREADY, 0);
            @(posedge clk); #1;
        end
        wdat_full = 1'b0;
        beat(4'd5, 0);
        beat(4'd5, 1);
        wait_idle();

        // Early WLAST at beat 2 of len 3 (FIXED, size 2)
        push_cmd(4'd2, 2'd0, 4'd3, 2'd2, 2'b00, 4'b1111, 1'b1, 2'b10, 1, 1);
        wait_load();
        beats(4'd2, 3);
        wait_idle();

        // WLAST only at beat 5 of len 3 (WRAP treated as INCR)
        push_cmd(4'd7, 2'd3, 4'd3, 2'd0, 2'b10, 4'b1000, 1'b0, 2'b10, 1, 1);
        wait_load();
        beats(4'd7, 6);
        wait_idle();

        // Foreign WID beats are ignored
        push_cmd(4'd5, 2'd0, 4'd1, 2'd1, 2'b01, 4'b0011, 1'b0, 2'b00, 1, 1);
        wait_load();
        beat(4'd3, 0);
        beat(4'd3, 1);
        beat(4'd3, 0);
        beat(4'd5, 0);
        beat(4'd5, 1);
        wait_idle();

        // Queue fill while a B response is stalled
        bresp_ready = 1'b0;
        push_cmd(4'd8, 2'd0, 4'd0, 2'd2, 2'b01, 4'b1111, 1'b0, 2'b00, 1, 1);
        wait_load();
        beat(4'd8, 1);
        push_cmd(4'd1, 2'd2, 4'd0, 2'd3, 2'b00, 4'b1111, 1'b1, 2'b00, 1, 1);
        push_cmd(4'd4, 2'd3, 4'd1, 2'd1, 2'b01, 4'b1100, 1'b0, 2'b00, 1, 1);
        push_cmd(4'd6, 2'd1, 4'd0, 2'd0, 2'b11, 4'b0010, 1'b0, 2'b00, 1, 1);
        push_cmd(4'd9, 2'd0, 4'd2, 2'd2, 2'b01, 4'b1111, 1'b0, 2'b00, 1, 1);
        @(negedge clk);
        chk("cmd_ready_full", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_id = 4'd15; cmd_len = 4'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_bvalid", bresp_valid, 1);
            chk("hold_bid", bresp_id, 8);
            chk("hold_bresp", bresp_resp, 0);
            chk("hold_no_load", wready_req, 0);
        end
        @(posedge clk); #1;
        bresp_ready = 1'b1;
        @(negedge clk);
        chk("hs_bvalid", bresp_valid, 1);
        @(negedge clk);
        chk("hs_m1_req", wready_req, 0);
        @(negedge clk);
        chk("hs_m2_req", wready_req, 1);
        @(posedge clk); #1;
        beat(4'd1, 1);
        wait_load();
        beats(4'd4, 2);
        wait_load();
        beat(4'd6, 1);
        wait_load();
        beats(4'd9, 3);
        wait_idle();

        // Reset during DATA discards the active burst and the queue
        push_cmd(4'd5, 2'd0, 4'd3, 2'd2, 2'b01, 4'b1111, 1'b0, 2'b00, 1, 0);
        push_cmd(4'd6, 2'd0, 4'd0, 2'd2, 2'b01, 4'b1111, 1'b0, 2'b00, 0, 0);
        wait_load();
        beat(4'd5, 0);
        AXI_WVALID = 1'b1; AXI_WID = 4'd5;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_wready", AXI_WREADY, 0);
        chk("mrst_bvalid", bresp_valid, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        AXI_WVALID = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("discard_no_load", wready_req, 0);
        end
        chk("discard_busy", busy, 0);

        chk("load_q_empty", exp_load.size(), 0);
        chk("b_q_empty", exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
